gp64_bit_divider: RTL and testbench

- Iterative 64-bit restoring divider for the RV64M DIV/DIVU/REM/REMU family.
- It is the subtract-based counterpart of the general-purpose 64-bit adder: one 65-bit trial subtraction per cycle.
- Sits beside the ALU in the central core. The core starts an operation, stalls on busy, and captures quotient and remainder on done.

---
 rtl/gp64_bit_divider_if.sv | 25 ++
 rtl/gp64_bit_divider.sv | 116 +++++++++++
 tb/tb_gp64_bit_divider.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gp64_bit_divider_if.sv
// rtl/gp64_bit_divider_if.sv - start/operand/result bundle between core and divider
interface gp64_bit_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             isSigned;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Core side: issues operations, observes status and results
    modport master (
        output start, isSigned, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    // Divider side
    modport slave (
        input  start, isSigned, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/gp64_bit_divider.sv
// rtl/gp64_bit_divider.sv - iterative 64-bit restoring divider (DIV/DIVU/REM/REMU)
module gp64_bit_divider #(
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    gp64_bit_divider_if.slave       bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    state_t           state_q;
    logic [5:0]       cnt_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] dq_q;        // dividend shifts out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [WIDTH-1:0] div_q;       // working (absolute) divisor
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   shifted_d;
    logic             borrow_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] dvd_abs_d;
    logic [WIDTH-1:0] dvs_abs_d;
    logic             div_zero_d;
    logic             ovf_d;

    // Trial subtraction for one restoring step and operand preparation at accept
    always_comb begin
        shifted_d  = {rem_q, dq_q[WIDTH-1]};
        // The shifted remainder may need WIDTH+1 bits; compare at full width, and the
        // low WIDTH bits of the difference are exact whenever there is no borrow.
        borrow_d   = (shifted_d < {1'b0, div_q});
        diff_d     = shifted_d[WIDTH-1:0] - div_q;
        dvd_abs_d  = (bus.isSigned && bus.dividend[WIDTH-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_abs_d  = (bus.isSigned && bus.divisor[WIDTH-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;
        div_zero_d = (bus.divisor == '0);
        ovf_d      = bus.isSigned && (bus.dividend == MIN_NEG) && (bus.divisor == ALL_ONE);
    end

    // Control FSM with datapath; all outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dq_q        <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // The done cycle is still part of the operation, so start is ignored there
                    busy_q <= !done_q && bus.start;
                    if (!done_q && bus.start) begin
                        if (div_zero_d) begin
                            dq_q    <= ALL_ONE;
                            rem_q   <= bus.dividend;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= S_FIX;
                        end else if (ovf_d) begin
                            dq_q    <= MIN_NEG;
                            rem_q   <= '0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= S_FIX;
                        end else begin
                            dq_q    <= dvd_abs_d;
                            rem_q   <= '0;
                            div_q   <= dvs_abs_d;
                            neg_q_q <= bus.isSigned && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            neg_r_q <= bus.isSigned && bus.dividend[WIDTH-1];
                            cnt_q   <= 6'd63;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= borrow_d ? shifted_d[WIDTH-1:0] : diff_d;
                    dq_q  <= {dq_q[WIDTH-2:0], ~borrow_d};
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient_q  <= neg_q_q ? (~dq_q + 1'b1) : dq_q;
                    remainder_q <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
                    done_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_gp64_bit_divider.sv
// tb/tb_gp64_bit_divider.sv - scoreboard bench for gp64_bit_divider
module tb_gp64_bit_divider;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          start_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gp64_bit_divider_if #(.WIDTH(64)) bus ();
    gp64_bit_divider #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                check64("quotient", bus.quotient, mon_e.q);
                check64("remainder", bus.remainder, mon_e.r);
                check64("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [63:0] dvd, input logic [63:0] dvs, input logic sgn,
                         input logic [63:0] q, input logic [63:0] r, input int lat);
        exp_t e;
        @(posedge clk); #1;
        check64("busy_idle", 64'(bus.busy), 64'd0);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.isSigned = sgn;
        e.q = q; e.r = r; e.start_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check64("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 120 cycles");
        end else begin
            check64("busy_in_done", 64'(bus.busy), 64'd1);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.isSigned = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check64("rst_busy", 64'(bus.busy), 64'd0);
        check64("rst_done", 64'(bus.done), 64'd0);
        check64("rst_quotient", bus.quotient, 64'd0);
        check64("rst_remainder", bus.remainder, 64'd0);
        rst = 1'b0;

        issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66);                       wait_done();
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66);          wait_done();
        issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 66);                            wait_done();
        issue(64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
              64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66);                           wait_done();
        issue(64'h1234, 64'd0, 1'b0, ONES, 64'h1234, 2);                      wait_done();
        issue(64'h1234, 64'd0, 1'b1, ONES, 64'h1234, 2);                      wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, ONES,
              64'hFFFF_FFFF_FFFF_FFFB, 2);                                    wait_done();
        issue(MINN, ONES, 1'b1, MINN, 64'd0, 2);                              wait_done();
        issue(ONES, 64'h8000_0000_0000_0001, 1'b0, 64'd1,
              64'h7FFF_FFFF_FFFF_FFFE, 66);                                   wait_done();
        issue(MINN, ONES, 1'b0, 64'd0, MINN, 66);                             wait_done();

        // Start pulsed mid-operation is ignored; previous results stay on the ports
        issue(64'd1000, 64'd7, 1'b0, 64'd142, 64'd6, 66);
        repeat (29) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 64'd5;
        bus.divisor  = 64'd1;
        check64("hold_quotient", bus.quotient, 64'd0);
        check64("hold_remainder", bus.remainder, MINN);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Reset mid-run abandons the operation
        issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66);
        repeat (38) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check64("abort_busy", 64'(bus.busy), 64'd0);
        check64("abort_done", 64'(bus.done), 64'd0);
        check64("abort_quotient", bus.quotient, 64'd0);
        check64("abort_remainder", bus.remainder, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check64("abort_quiet_busy", 64'(bus.busy), 64'd0);

        issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66);                       wait_done();

        @(negedge clk);
        check64("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
